// File: rtl/repairmb_pkg.sv
// REPAIRMB sideband message codes, lane-map constants and FSM states shared by
// the REPAIRMB initiator and responder.
package repairmb_pkg;

    localparam int unsigned MSG_W = 4;
    localparam int unsigned MAP_W = 2;

    localparam logic [MSG_W-1:0] MSG_START_REQ          = 4'b0001;
    localparam logic [MSG_W-1:0] MSG_START_RESP         = 4'b0010;
    localparam logic [MSG_W-1:0] MSG_END_REQ            = 4'b0011;
    localparam logic [MSG_W-1:0] MSG_END_RESP           = 4'b0100;
    localparam logic [MSG_W-1:0] MSG_APPLY_DEGRADE_REQ  = 4'b0101;
    localparam logic [MSG_W-1:0] MSG_APPLY_DEGRADE_RESP = 4'b0110;

    localparam logic [MAP_W-1:0] LANES_ALL  = 2'b11;
    localparam logic [MAP_W-1:0] LANES_LOW  = 2'b01;
    localparam logic [MAP_W-1:0] LANES_HIGH = 2'b10;
    localparam logic [MAP_W-1:0] LANES_NONE = 2'b00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_BUSY_START,
        ST_SEND_START_RESP,
        ST_WAIT_REQ,
        ST_BUSY_DEGRADE,
        ST_SEND_DEGRADE_RESP,
        ST_BUSY_END,
        ST_SEND_END_RESP,
        ST_DONE,
        ST_ERROR
    } repairmb_state_e;

    // Response code driven while sitting in a SEND state, zero elsewhere.
    function automatic logic [MSG_W-1:0] resp_code(input repairmb_state_e s);
        case (s)
            ST_SEND_START_RESP:   return MSG_START_RESP;
            ST_SEND_DEGRADE_RESP: return MSG_APPLY_DEGRADE_RESP;
            ST_SEND_END_RESP:     return MSG_END_RESP;
            default:              return '0;
        endcase
    endfunction

    // True for states that present a response on the sideband TX port.
    function automatic logic is_send_state(input repairmb_state_e s);
        return (s == ST_SEND_START_RESP) || (s == ST_SEND_DEGRADE_RESP) ||
               (s == ST_SEND_END_RESP);
    endfunction

endpackage

// File: rtl/sb_timeout_counter.sv
// Idle-cycle watchdog for sideband handshakes: counts while enabled and flags
// the cycle on which TIMEOUT_CYCLES-1 has been reached.
module sb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 800000
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count idle cycles, saturating at the last value until cleared.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && (cnt != CNT_LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = count_en && (cnt == CNT_LAST);

endmodule

// File: rtl/repairmb_responder.sv
// Partner-facing side of the MBINIT.REPAIRMB handshake: answers start,
// apply_degrade and end requests and tracks the partner's degrade lane map.
module repairmb_responder
    import repairmb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 800000
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             MBINIT_REVERSALMB_end,
    input  logic [MSG_W-1:0] i_RX_SbMessage,
    input  logic             i_msg_valid,
    input  logic [2:0]       i_msg_info,
    input  logic             i_Busy_SideBand,
    input  logic             i_falling_edge_busy,
    output logic [MSG_W-1:0] o_TX_SbMessage,
    output logic             o_ValidOutDatat_REPAIRMB_responder,
    output logic             o_Start_Repeater,
    output logic             o_apply_repeater,
    output logic [MAP_W-1:0] o_Partner_Functional_Lanes,
    output logic             o_REPAIRMB_responder_end,
    output logic             o_error
);

    repairmb_state_e  state;
    repairmb_state_e  ns;
    logic [MAP_W-1:0] rx_map_c;
    logic             deg_accept_c;
    logic             end_accept_c;
    logic             send_done_c;
    logic             timeout_hit_c;
    logic             tmo_clear_c;
    logic             tmo_count_en_c;
    logic             tmo_expired;
    logic             unused_info_c;

    assign rx_map_c      = i_msg_info[MAP_W-1:0];
    assign unused_info_c = i_msg_info[2];

    // Watchdog for the two states that wait on the partner.
    sb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .clear    (tmo_clear_c),
        .count_en (tmo_count_en_c),
        .expired  (tmo_expired)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= ns;
        end
    end

    // Next-state decode plus the qualifiers consumed by the output registers.
    always_comb begin
        ns             = state;
        deg_accept_c   = 1'b0;
        end_accept_c   = 1'b0;
        send_done_c    = i_falling_edge_busy && !i_Busy_SideBand;
        // A valid (even ignored) message restarts the idle window, so it never times out.
        timeout_hit_c  = tmo_expired && !i_msg_valid;
        tmo_count_en_c = (state == ST_WAIT_START) || (state == ST_WAIT_REQ);

        if (!MBINIT_REVERSALMB_end) begin
            ns = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: ns = ST_WAIT_START;
                ST_WAIT_START: begin
                    if (i_msg_valid && (i_RX_SbMessage == MSG_START_REQ)) begin
                        ns = ST_BUSY_START;
                    end else if (timeout_hit_c) begin
                        ns = ST_ERROR;
                    end
                end
                ST_BUSY_START:   if (!i_Busy_SideBand) ns = ST_SEND_START_RESP;
                ST_BUSY_DEGRADE: if (!i_Busy_SideBand) ns = ST_SEND_DEGRADE_RESP;
                ST_BUSY_END:     if (!i_Busy_SideBand) ns = ST_SEND_END_RESP;
                ST_SEND_START_RESP:   if (send_done_c) ns = ST_WAIT_REQ;
                ST_SEND_DEGRADE_RESP: if (send_done_c) ns = ST_WAIT_REQ;
                ST_SEND_END_RESP:     if (send_done_c) ns = ST_DONE;
                ST_WAIT_REQ: begin
                    if (i_msg_valid && (i_RX_SbMessage == MSG_APPLY_DEGRADE_REQ)) begin
                        if (rx_map_c == LANES_NONE) begin
                            ns = ST_ERROR;
                        end else begin
                            ns           = ST_BUSY_DEGRADE;
                            deg_accept_c = 1'b1;
                        end
                    end else if (i_msg_valid && (i_RX_SbMessage == MSG_END_REQ)) begin
                        ns           = ST_BUSY_END;
                        end_accept_c = 1'b1;
                    end else if (timeout_hit_c) begin
                        ns = ST_ERROR;
                    end
                end
                ST_DONE:  ns = ST_DONE;
                ST_ERROR: ns = ST_ERROR;
                default:  ns = ST_IDLE;
            endcase
        end

        tmo_clear_c = (ns != state) || i_msg_valid;
    end

    // Registered outputs decoded from the next state; lane map and repeater flags held.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            o_TX_SbMessage                     <= '0;
            o_ValidOutDatat_REPAIRMB_responder <= 1'b0;
            o_Start_Repeater                   <= 1'b0;
            o_apply_repeater                   <= 1'b0;
            o_Partner_Functional_Lanes         <= LANES_ALL;
            o_REPAIRMB_responder_end           <= 1'b0;
            o_error                            <= 1'b0;
        end else begin
            o_TX_SbMessage                     <= resp_code(ns);
            o_ValidOutDatat_REPAIRMB_responder <= is_send_state(ns);
            o_REPAIRMB_responder_end           <= (ns == ST_DONE);
            o_error                            <= (ns == ST_ERROR);
            o_Start_Repeater                   <= deg_accept_c && (rx_map_c != LANES_ALL);

            if (!MBINIT_REVERSALMB_end) begin
                o_Partner_Functional_Lanes <= LANES_ALL;
                o_apply_repeater           <= 1'b0;
            end else if (deg_accept_c) begin
                o_Partner_Functional_Lanes <= rx_map_c;
                o_apply_repeater           <= (rx_map_c != LANES_ALL);
            end else if (end_accept_c) begin
                o_apply_repeater <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_repairmb_responder.sv
// Directed bench for repairmb_responder with a transaction-level reference model.
module tb_repairmb_responder;

    localparam int T = 16;

    localparam logic [3:0] C_START_REQ  = 4'b0001;
    localparam logic [3:0] C_START_RESP = 4'b0010;
    localparam logic [3:0] C_END_REQ    = 4'b0011;
    localparam logic [3:0] C_END_RESP   = 4'b0100;
    localparam logic [3:0] C_DEG_REQ    = 4'b0101;
    localparam logic [3:0] C_DEG_RESP   = 4'b0110;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] rx_msg;
    logic       rx_valid;
    logic [2:0] rx_info;
    logic       busy;
    logic       fall;
    logic [3:0] tx_msg;
    logic       tx_valid;
    logic       start_rep;
    logic       apply_rep;
    logic [1:0] lanes;
    logic       resp_end;
    logic       err;

    always #5 CLK = ~CLK;

    repairmb_responder #(.TIMEOUT_CYCLES(T)) dut (
        .CLK                                (CLK),
        .rst_n                              (rst_n),
        .MBINIT_REVERSALMB_end              (en),
        .i_RX_SbMessage                     (rx_msg),
        .i_msg_valid                        (rx_valid),
        .i_msg_info                         (rx_info),
        .i_Busy_SideBand                    (busy),
        .i_falling_edge_busy                (fall),
        .o_TX_SbMessage                     (tx_msg),
        .o_ValidOutDatat_REPAIRMB_responder (tx_valid),
        .o_Start_Repeater                   (start_rep),
        .o_apply_repeater                   (apply_rep),
        .o_Partner_Functional_Lanes         (lanes),
        .o_REPAIRMB_responder_end           (resp_end),
        .o_error                            (err)
    );

    // Reference model: stage 0 off, 1 awaiting start, 2 awaiting requests, 3 done, 4 error.
    int         m_stage;
    int         m_wait;
    logic [3:0] m_owed;
    logic       m_sending;
    logic [3:0] m_code;
    logic       m_valid;
    logic       m_pulse;
    logic       m_apply;
    logic       m_end;
    logic       m_err;
    logic [1:0] m_lanes;

    always @(posedge CLK) begin
        if (!rst_n || !en) begin
            m_stage   <= 0;
            m_wait    <= 0;
            m_owed    <= 4'd0;
            m_sending <= 1'b0;
            m_code    <= 4'd0;
            m_valid   <= 1'b0;
            m_pulse   <= 1'b0;
            m_apply   <= 1'b0;
            m_end     <= 1'b0;
            m_err     <= 1'b0;
            m_lanes   <= 2'b11;
        end else begin
            m_pulse <= 1'b0;
            if (m_stage == 0) begin
                m_stage <= 1;
                m_wait  <= 0;
            end else if (m_owed != 4'd0) begin
                m_wait <= 0;
                if (!m_sending) begin
                    if (!busy) begin
                        m_sending <= 1'b1;
                        m_valid   <= 1'b1;
                        m_code    <= m_owed;
                    end
                end else if (fall && !busy) begin
                    m_sending <= 1'b0;
                    m_owed    <= 4'd0;
                    m_valid   <= 1'b0;
                    m_code    <= 4'd0;
                    if (m_owed == C_END_RESP) begin
                        m_stage <= 3;
                        m_end   <= 1'b1;
                    end else begin
                        m_stage <= 2;
                    end
                end
            end else if (m_stage == 1 || m_stage == 2) begin
                if (rx_valid && m_stage == 1 && rx_msg == C_START_REQ) begin
                    m_owed <= C_START_RESP;
                end else if (rx_valid && m_stage == 2 && rx_msg == C_DEG_REQ) begin
                    if (rx_info[1:0] == 2'b00) begin
                        m_stage <= 4;
                        m_err   <= 1'b1;
                    end else begin
                        m_owed  <= C_DEG_RESP;
                        m_lanes <= rx_info[1:0];
                        m_apply <= (rx_info[1:0] != 2'b11);
                        m_pulse <= (rx_info[1:0] != 2'b11);
                    end
                end else if (rx_valid && m_stage == 2 && rx_msg == C_END_REQ) begin
                    m_owed  <= C_END_RESP;
                    m_apply <= 1'b0;
                end else if (rx_valid) begin
                    m_wait <= 0;
                end else if (m_wait == T - 1) begin
                    m_stage <= 4;
                    m_err   <= 1'b1;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end
        end
    end

    int         n_total = 0;
    int         n_pass  = 0;
    int         n_pulse = 0;
    int         n_valid = 0;
    bit         apply_seen = 1'b0;
    logic [3:0] rc [3];
    int         n_rc = 0;
    logic [3:0] last_code = 4'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    endtask

    // Advance n cycles; after each edge compare every output against the model.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            chk("code",  32'(tx_msg),    32'(m_code));
            chk("valid", 32'(tx_valid),  32'(m_valid));
            chk("start_rep", 32'(start_rep), 32'(m_pulse));
            chk("apply", 32'(apply_rep), 32'(m_apply));
            chk("lanes", 32'(lanes),     32'(m_lanes));
            chk("end",   32'(resp_end),  32'(m_end));
            chk("error", 32'(err),       32'(m_err));
            if (start_rep === 1'b1) n_pulse++;
            if (apply_rep === 1'b1) apply_seen = 1'b1;
            if (tx_valid === 1'b1) n_valid++;
        end
    endtask

    task automatic send(input logic [3:0] code, input logic [1:0] map);
        rx_valid = 1'b1;
        rx_msg   = code;
        rx_info  = {1'b0, map};
        step(1);
        rx_valid = 1'b0;
        rx_msg   = 4'd0;
        rx_info  = 3'd0;
    endtask

    // Wait for a response, then hold busy for nb cycles and end with a falling-edge pulse.
    task automatic serve(input int nb);
        for (int i = 0; i < 20 && tx_valid !== 1'b1; i++) step(1);
        if (tx_valid !== 1'b1) begin
            chk("resp_wait_timeout", 32'(tx_valid), 32'd1);
        end else begin
            last_code = tx_msg;
            if (n_rc < 3) rc[n_rc] = tx_msg;
            n_rc++;
            busy = 1'b1;
            step(nb);
            busy = 1'b0;
            fall = 1'b1;
            step(1);
            fall = 1'b0;
        end
    endtask

    task automatic restart();
        en = 1'b0;
        step(1);
        en = 1'b1;
        step(1);
        n_pulse    = 0;
        n_valid    = 0;
        apply_seen = 1'b0;
        n_rc       = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int hit;
        rst_n = 1'b0; en = 1'b0; rx_msg = 4'd0; rx_valid = 1'b0;
        rx_info = 3'd0; busy = 1'b0; fall = 1'b0;
        step(2);
        chk("rst_lanes", 32'(lanes), 32'h3);
        chk("rst_valid", 32'(tx_valid), 32'h0);
        chk("rst_error", 32'(err), 32'h0);
        rst_n = 1'b1;

        // Nominal: start, degrade 11, end with 3-cycle busy bursts.
        restart();
        send(C_START_REQ, 2'b00); serve(3);
        send(C_DEG_REQ, 2'b11);   serve(3);
        send(C_END_REQ, 2'b00);   serve(3);
        chk("nom_count", 32'(n_rc), 32'd3);
        chk("nom_r0", 32'(rc[0]), 32'h2);
        chk("nom_r1", 32'(rc[1]), 32'h6);
        chk("nom_r2", 32'(rc[2]), 32'h4);
        chk("nom_end", 32'(resp_end), 32'h1);
        chk("nom_lanes", 32'(lanes), 32'h3);
        chk("nom_apply_never", 32'(apply_seen), 32'h0);

        // Repeat: degrade 01, stray start ignored, degrade 11, end.
        restart();
        send(C_START_REQ, 2'b00); serve(2);
        send(C_DEG_REQ, 2'b01);   serve(2);
        chk("rep_apply_mid", 32'(apply_rep), 32'h1);
        chk("rep_lanes_mid", 32'(lanes), 32'h1);
        send(C_START_REQ, 2'b00); step(2);
        send(C_DEG_REQ, 2'b11);   serve(2);
        chk("rep_apply_after", 32'(apply_rep), 32'h0);
        send(C_END_REQ, 2'b00);   serve(2);
        chk("rep_pulses", 32'(n_pulse), 32'd1);
        chk("rep_lanes_final", 32'(lanes), 32'h3);
        chk("rep_end", 32'(resp_end), 32'h1);

        // Fatal: map 00 goes straight to error with no response.
        restart();
        send(C_START_REQ, 2'b00); serve(1);
        n_valid = 0;
        send(C_DEG_REQ, 2'b00);
        chk("fat_error_next", 32'(err), 32'h1);
        step(5);
        chk("fat_no_resp", 32'(n_valid), 32'd0);
        chk("fat_error_hold", 32'(err), 32'h1);

        // Busy stall: 10 busy cycles, valid exactly one cycle after release.
        restart();
        busy = 1'b1;
        send(C_START_REQ, 2'b00);
        step(9);
        chk("stall_no_valid", 32'(n_valid), 32'd0);
        busy = 1'b0;
        step(1);
        chk("stall_valid", 32'(tx_valid), 32'h1);
        chk("stall_code", 32'(tx_msg), 32'h2);
        busy = 1'b1; fall = 1'b1;
        step(1);
        fall = 1'b0;
        chk("stall_fall_while_busy", 32'(tx_valid), 32'h1);
        serve(1);

        // Abort in SEND_DEGRADE_RESP, then re-enable.
        restart();
        send(C_START_REQ, 2'b00); serve(1);
        send(C_DEG_REQ, 2'b10);
        step(1);
        chk("abort_pre_valid", 32'(tx_valid), 32'h1);
        chk("abort_pre_apply", 32'(apply_rep), 32'h1);
        en = 1'b0;
        step(1);
        chk("abort_valid", 32'(tx_valid), 32'h0);
        chk("abort_apply", 32'(apply_rep), 32'h0);
        chk("abort_lanes", 32'(lanes), 32'h3);
        en = 1'b1;
        step(1);
        send(C_START_REQ, 2'b00); serve(1);
        chk("abort_restart", 32'(last_code), 32'h2);

        // Timeout: error 16 edges after entering WAIT_START.
        en = 1'b0;
        step(1);
        en = 1'b1;
        step(1);
        hit = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (err === 1'b1 && hit < 0) hit = i;
        end
        chk("tmo_cycle", 32'(hit), 32'd16);

        // Synchronous reset: no effect until the next CLK edge.
        restart();
        send(C_START_REQ, 2'b00);
        step(1);
        rst_n = 1'b0;
        #2;
        chk("rst_sync_hold", 32'(tx_valid), 32'h1);
        step(1);
        chk("rst_sync_valid", 32'(tx_valid), 32'h0);
        chk("rst_sync_lanes", 32'(lanes), 32'h3);
        rst_n = 1'b1;
        step(2);
        en = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
